// File: rtl/drf_port_host.sv
// Host-side bridge for the DRF 4-bit port: TX bytes go out as 2-bit chunks on a req/ack toggle, and RX chunks are reassembled into bytes.
// TX accepts one byte per handshake; tx_ready is low while a byte is in flight. RX bytes wait in a show-ahead FIFO and are dropped (sticky overflow) when it is full.
module drf_port_host #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overflow,
   output logic [3:0] port_to_cpu,
   input  logic [3:0] port_from_cpu
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {ST_IDLE, ST_WAIT_ACK} tx_state_e;

   tx_state_e   state_q, state_d;
   logic        req_q, req_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  byte_q, byte_d;
   logic [3:0]  port_q, port_d;
   logic [3:0]  smp_q, smp_d;
   logic        prev_q, prev_d;
   logic [5:0]  sh_q, sh_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];

   logic       tx_accept, tx_ack;
   logic [7:0] tx_shifted;
   logic       rx_event, rx_push, rx_pop, fifo_full, fifo_empty, push_ok;
   logic [7:0] rx_byte;

   assign tx_accept = (state_q == ST_IDLE) && tx_valid;
   assign tx_ack    = (state_q == ST_WAIT_ACK) && (smp_q[3] == req_q);

   // TX next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (tx_valid) state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: if (tx_ack && idx_q == 2'd3) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // TX outputs and datapath
   always_comb begin
      req_d      = req_q;
      idx_d      = idx_q;
      byte_d     = byte_q;
      port_d     = port_q;
      tx_shifted = 8'd0;
      tx_ready   = (state_q == ST_IDLE);
      if (tx_accept) begin
         byte_d = tx_data;
         idx_d  = 2'd0;
         req_d  = ~req_q;
         port_d = {~req_q, 1'b1, tx_data[7:6]};
      end else if (tx_ack && idx_q != 2'd3) begin
         idx_d      = idx_q + 2'd1;
         req_d      = ~req_q;
         tx_shifted = byte_q << {idx_d, 1'b0};
         port_d     = {~req_q, 1'b0, tx_shifted[7:6]};
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rx_event   = (smp_q[2] != prev_q);
   assign rx_push    = rx_event && (cnt_q == 2'd3);
   assign rx_byte    = {sh_q, smp_q[1:0]};
   assign rx_pop     = rx_ready && !fifo_empty;
   // A pop in the same cycle frees the slot, so a push on full is still taken.
   assign push_ok    = rx_push && (!fifo_full || rx_pop);

   always_comb begin
      smp_d    = port_from_cpu;
      prev_d   = prev_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q | (rx_push && !push_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rx_pop};
      if (rx_event) begin
         prev_d = smp_q[2];
         sh_d   = {sh_q[3:0], smp_q[1:0]};
         cnt_d  = cnt_q + 2'd1;
      end
      if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = rx_byte;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         idx_q    <= 2'd0;
         byte_q   <= 8'd0;
         port_q   <= 4'd0;
         smp_q    <= 4'd0;
         prev_q   <= 1'b0;
         sh_q     <= 6'd0;
         cnt_q    <= 2'd0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         idx_q    <= idx_d;
         byte_q   <= byte_d;
         port_q   <= port_d;
         smp_q    <= smp_d;
         prev_q   <= prev_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; rx_data is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign port_to_cpu = port_q;
   assign rx_valid    = !fifo_empty;
   assign rx_data     = fifo_empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];
   assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_drf_port_host.sv
// Directed plus randomized bench for drf_port_host with a queue-based reference model.
module tb_drf_port_host;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_overflow;
   logic [3:0] port_to_cpu;
   logic [3:0] pfc;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic       exp_req;
   logic       exp_ovf;
   logic [7:0] q[$];

   drf_port_host #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overflow(rx_overflow),
      .port_to_cpu(port_to_cpu), .port_from_cpu(pfc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] chunk(input logic [7:0] b, input int i);
      logic [7:0] t;
      t = (b >> (6 - 2 * i)) & 8'h03;
      return t[1:0];
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (q.size() == DEPTH) exp_ovf = 1'b1;
      else q.push_back(b);
   endtask

   task automatic reset_seq(input logic [3:0] garbage);
      reset = 1'b1;
      pfc   = garbage;
      tick();
      tick();
      chk("rst_port", {4'd0, port_to_cpu}, 8'h00);
      chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
      chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_ovf", {7'd0, rx_overflow}, 8'h00);
      pfc     = 4'd0;
      reset   = 1'b0;
      exp_req = 1'b0;
      exp_ovf = 1'b0;
      q.delete();
   endtask

   // One byte slot: optional TX byte (bench acks after dly cycles) and optional RX byte
   // whose chunks are toggled in together with each ack; nch < 4 stops early.
   task automatic xfer(input logic [7:0] tb, input bit do_tx, input logic [7:0] rb,
                       input bit do_rx, input int dly, input int nch, input bit pop_last);
      logic [3:0] e;
      if (do_tx) begin
         chk("tx_ready_before", {7'd0, tx_ready}, 8'h01);
         tx_data  = tb;
         tx_valid = 1'b1;
         tick();
         tx_valid = 1'b0;
      end
      for (int i = 0; i < nch; i++) begin
         if (do_tx) begin
            exp_req = ~exp_req;
            e = {exp_req, (i == 0), chunk(tb, i)};
            chk("tx_port", {4'd0, port_to_cpu}, {4'd0, e});
            chk("tx_ready_busy", {7'd0, tx_ready}, 8'h00);
            for (int d = 0; d < dly; d++) begin
               tick();
               chk("tx_port_hold", {4'd0, port_to_cpu}, {4'd0, e});
            end
            pfc[3] = exp_req;
         end
         if (do_rx) begin
            pfc[2]   = ~pfc[2];
            pfc[1:0] = chunk(rb, i);
         end
         tick();
         if (do_rx && i == 3) begin
            chk("rx_valid_early", {7'd0, rx_valid}, {7'd0, (q.size() != 0)});
            if (pop_last) rx_ready = 1'b1;
         end
         tick();
         rx_ready = 1'b0;
         if (do_rx && i == 3) begin
            if (pop_last) begin
               void'(q.pop_front());
               q.push_back(rb);
            end else begin
               model_push(rb);
            end
            chk("rx_valid_after", {7'd0, rx_valid}, 8'h01);
            chk("rx_ovf", {7'd0, rx_overflow}, {7'd0, exp_ovf});
         end
      end
      if (do_tx && nch == 4) chk("tx_ready_done", {7'd0, tx_ready}, 8'h01);
   endtask

   task automatic pop_one;
      chk("pop_valid", {7'd0, rx_valid}, 8'h01);
      chk("pop_data", rx_data, q[0]);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      void'(q.pop_front());
   endtask

   task automatic drain;
      while (q.size() > 0) pop_one();
      chk("drain_empty", {7'd0, rx_valid}, 8'h00);
   endtask

   initial begin
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      rx_ready = 1'b1;
      exp_req  = 1'b0;
      exp_ovf  = 1'b0;
      reset_seq(4'b1101);
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      tick();
      chk("idle_port", {4'd0, port_to_cpu}, 8'h00);
      chk("idle_tx_ready", {7'd0, tx_ready}, 8'h01);

      // TX 0xB4 with slow acks: expected chunks 1110, 0011, 1001, 0000
      xfer(8'hB4, 1'b1, 8'h00, 1'b0, 3, 4, 1'b0);

      // TX stall: no ack ever; a second tx_valid must be ignored
      tx_data  = 8'hB4;
      tx_valid = 1'b1;
      tick();
      tx_data  = 8'h5A;
      chk("stall_port0", {4'd0, port_to_cpu}, 8'h0E);
      for (int c = 0; c < 50; c++) begin
         tick();
         chk("stall_port", {4'd0, port_to_cpu}, 8'h0E);
         chk("stall_tx_ready", {7'd0, tx_ready}, 8'h00);
      end
      tx_valid = 1'b0;
      reset_seq(4'b1010);

      // RX 0x67
      xfer(8'h00, 1'b0, 8'h67, 1'b1, 0, 4, 1'b0);
      chk("rx67_data", rx_data, 8'h67);
      drain();

      // Overflow: five bytes into a four-deep FIFO
      for (int b = 1; b <= 5; b++) xfer(8'h00, 1'b0, 8'(b), 1'b1, 0, 4, 1'b0);
      chk("ovf_set", {7'd0, rx_overflow}, 8'h01);
      drain();

      // Push with simultaneous pop on a full FIFO
      reset_seq(4'b0000);
      for (int b = 0; b < 4; b++) xfer(8'h00, 1'b0, 8'($urandom), 1'b1, 0, 4, 1'b0);
      xfer(8'h00, 1'b0, 8'hC3, 1'b1, 0, 4, 1'b1);
      chk("full_pushpop_ovf", {7'd0, rx_overflow}, 8'h00);
      drain();

      // Concurrent TX 0xA5 / RX 0x3C
      xfer(8'hA5, 1'b1, 8'h3C, 1'b1, 0, 4, 1'b0);
      drain();

      // Same again, interrupted by reset after TX chunk 1
      xfer(8'hA5, 1'b1, 8'h3C, 1'b1, 0, 2, 1'b0);
      reset_seq(4'b0111);
      xfer(8'($urandom), 1'b1, 8'($urandom), 1'b1, 1, 4, 1'b0);
      drain();

      // Randomized traffic
      for (int n = 0; n < 12; n++) begin
         bit dt, dr;
         dt = 1'($urandom);
         dr = 1'($urandom) | ~dt;
         xfer(8'($urandom), dt, 8'($urandom), dr, int'($urandom_range(0, 3)), 4, 1'b0);
         if ($urandom_range(0, 2) == 0) drain();
      end
      drain();
      chk("final_ovf", {7'd0, rx_overflow}, {7'd0, exp_ovf});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
